complex_multiplier_pipe: RTL and testbench

// - Pipelined, parametrised signed complex multiplier: y = a * b, or a * conj(b) when conj_b=1.
// - Next generation of the team's fixed 16x18 complex multiplier.
// - Adds valid/ready flow control with backpressure, a sideband tag, a conjugate mode and a scalable output shift.
// - Sits in the DSP datapath between sample sources (mixers, FFT twiddle stages) and downstream filters/accumulators.

---
 rtl/complex_multiplier_pipe.sv | 156 +++++++++++++++
 tb/tb_complex_multiplier_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_multiplier_pipe.sv
// complex_multiplier_pipe: three-stage pipelined signed complex multiplier,
// y = a * b or y = a * conj(b), with valid/ready flow control and a sideband tag.
// Optional macro ROUND_SAT_EN: round half-up before the output shift and
// saturate on narrowing (drives sat_flag). Without it the shift truncates,
// narrowing wraps, and sat_flag stays 0. Latency is 3 cycles in both builds.
module complex_multiplier_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 18,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 35,
  parameter int TAG_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   a_re,
  input  logic signed [A_WIDTH-1:0]   a_im,
  input  logic signed [B_WIDTH-1:0]   b_re,
  input  logic signed [B_WIDTH-1:0]   b_im,
  input  logic                        conj_b,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] y_re,
  output logic signed [OUT_WIDTH-1:0] y_im,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        sat_flag
);

  // BX holds b and its negation; PW holds one product; FW holds a sum of two products.
  localparam int BX = B_WIDTH + 1;
  localparam int PW = A_WIDTH + B_WIDTH + 1;
  localparam int FW = A_WIDTH + B_WIDTH + 2;

`ifdef ROUND_SAT_EN
  localparam logic signed [FW-1:0] RND     = (FW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [FW-1:0] SAT_MAX = (FW'(1) << (OUT_WIDTH - 1)) - FW'(1);
  localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                      v1;
  logic signed [A_WIDTH-1:0] a_re_s1, a_im_s1;
  logic signed [BX-1:0]      b_re_s1, b_im_s1;
  logic [TAG_WIDTH-1:0]      tag_s1;

  logic                      v2;
  logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
  logic [TAG_WIDTH-1:0]      tag_s2;

  logic signed [PW-1:0]      a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [FW-1:0]      re_sum, im_sum, re_adj, im_adj;
  logic [OUT_WIDTH:0]        re_red, im_red;
  logic                      sat_nxt;

  // Narrow a shifted full-width value to OUT_WIDTH; MSB of the result flags clipping.
  function automatic logic [OUT_WIDTH:0] reduce(input logic signed [FW-1:0] v);
`ifdef ROUND_SAT_EN
    if (v > SAT_MAX)
      reduce = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (v < SAT_MIN)
      reduce = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else
      reduce = {1'b0, v[OUT_WIDTH-1:0]};
`else
    reduce = {1'b0, v[OUT_WIDTH-1:0]};
`endif
  endfunction

  // Stage 1: capture operands and tag; conj(b) is applied here by negating b_im one bit wider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      a_re_s1 <= '0;
      a_im_s1 <= '0;
      b_re_s1 <= '0;
      b_im_s1 <= '0;
      tag_s1  <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        a_re_s1 <= a_re;
        a_im_s1 <= a_im;
        b_re_s1 <= {b_re[B_WIDTH-1], b_re};
        b_im_s1 <= conj_b ? -{b_im[B_WIDTH-1], b_im} : {b_im[B_WIDTH-1], b_im};
        tag_s1  <= in_tag;
      end
    end
  end

  assign a_re_x = PW'(a_re_s1);
  assign a_im_x = PW'(a_im_s1);
  assign b_re_x = PW'(b_re_s1);
  assign b_im_x = PW'(b_im_s1);

  // Stage 2: the four partial products, each exact in PW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
      tag_s2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        p_rr   <= a_re_x * b_re_x;
        p_ii   <= a_im_x * b_im_x;
        p_ri   <= a_re_x * b_im_x;
        p_ir   <= a_im_x * b_re_x;
        tag_s2 <= tag_s1;
      end
    end
  end

  assign re_sum = FW'(p_rr) - FW'(p_ii);
  assign im_sum = FW'(p_ri) + FW'(p_ir);

`ifdef ROUND_SAT_EN
  assign re_adj = (re_sum + RND) >>> OUT_SHIFT;
  assign im_adj = (im_sum + RND) >>> OUT_SHIFT;
`else
  assign re_adj = re_sum >>> OUT_SHIFT;
  assign im_adj = im_sum >>> OUT_SHIFT;
`endif

  assign re_red  = reduce(re_adj);
  assign im_red  = reduce(im_adj);
  assign sat_nxt = re_red[OUT_WIDTH] | im_red[OUT_WIDTH];

  // Stage 3: registered outputs; they only change when the pipe advances, so a stalled beat holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      out_tag   <= '0;
      sat_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        y_re     <= re_red[OUT_WIDTH-1:0];
        y_im     <= im_red[OUT_WIDTH-1:0];
        out_tag  <= tag_s2;
        sat_flag <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_complex_multiplier_pipe.sv
// tb_complex_multiplier_pipe: drives a default-parameter multiplier and a
// narrow OUT_SHIFT=4 / OUT_WIDTH=8 copy from the same stimulus, and checks
// both against an integer reference model. Honors ROUND_SAT_EN like the design.
module tb_complex_multiplier_pipe;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_ready1;
  logic signed [15:0] a_re, a_im;
  logic signed [17:0] b_re, b_im;
  logic               conj_b;
  logic [7:0]         in_tag;
  logic               out_ready;

  logic               out_valid0, sat0;
  logic signed [34:0] y_re0, y_im0;
  logic [7:0]         out_tag0;

  logic               out_valid1, sat1;
  logic signed [7:0]  y_re1, y_im1;
  logic [7:0]         out_tag1;

  int tests;
  int failures;

  typedef struct {
    longint ar, ai, br, bi;
    bit     cj;
    longint tg;
  } beat_t;

  beat_t sbq[$];

  bit                 hold_pending;
  logic signed [34:0] held_re, held_im;
  logic [7:0]         held_tag;

  complex_multiplier_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_b(conj_b),
    .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
    .y_re(y_re0), .y_im(y_im0), .out_tag(out_tag0), .sat_flag(sat0)
  );

  complex_multiplier_pipe #(.OUT_SHIFT(4), .OUT_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_b(conj_b),
    .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
    .y_re(y_re1), .y_im(y_im1), .out_tag(out_tag1), .sat_flag(sat1)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something hangs.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Narrow a full-precision value the way the output stage should.
  function automatic void reduce_ref(input longint v, input int sh, input int w,
                                     output longint r, output bit sat);
    longint maxv;
    sat = 1'b0;
`ifdef ROUND_SAT_EN
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    if (v > maxv) begin
      r = maxv; sat = 1'b1;
    end else if (v < -maxv - 1) begin
      r = -maxv - 1; sat = 1'b1;
    end else begin
      r = v;
    end
`else
    maxv = 0;
    v = v >>> sh;
    r = (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  function automatic void model(input beat_t b, input int sh, input int w,
                                output longint yr, output longint yi, output bit sat);
    longint bim, re, im;
    bit s_re, s_im;
    bim = b.cj ? -b.bi : b.bi;
    re  = b.ar * b.br - b.ai * bim;
    im  = b.ar * bim + b.ai * b.br;
    reduce_ref(re, sh, w, yr, s_re);
    reduce_ref(im, sh, w, yi, s_im);
    sat = s_re | s_im;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t  b;
    longint er, ei;
    bit     es;
    if (!rst_n) begin
      sbq.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", out_valid0, 1);
        checkOutput("hold_y_re", y_re0, held_re);
        checkOutput("hold_y_im", y_im0, held_im);
        checkOutput("hold_tag", out_tag0, held_tag);
        hold_pending = 1'b0;
      end
      if (out_valid0 && !out_ready) begin
        checkOutput("in_ready_full", in_ready, 0);
        held_re = y_re0; held_im = y_im0; held_tag = out_tag0;
        hold_pending = 1'b1;
      end
      if (in_valid) checkOutput("dut1_in_ready", in_ready1, in_ready);
      if (out_valid0 && out_ready) begin
        checkOutput("dut1_out_valid", out_valid1, 1);
        if (sbq.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          b = sbq.pop_front();
          model(b, 0, 35, er, ei, es);
          checkOutput("sb_y_re", y_re0, er);
          checkOutput("sb_y_im", y_im0, ei);
          checkOutput("sb_tag", out_tag0, b.tg);
          checkOutput("sb_sat", sat0, es);
          model(b, 4, 8, er, ei, es);
          checkOutput("sb1_y_re", y_re1, er);
          checkOutput("sb1_y_im", y_im1, ei);
          checkOutput("sb1_tag", out_tag1, b.tg);
          checkOutput("sb1_sat", sat1, es);
        end
      end
      if (in_valid && in_ready)
        sbq.push_back('{longint'(a_re), longint'(a_im), longint'(b_re), longint'(b_im),
                        conj_b, longint'(in_tag)});
    end
  end

  // Present one beat and hold it until the pipe accepts it.
  task automatic applyStimulus(input logic signed [15:0] ar, input logic signed [15:0] ai,
                               input logic signed [17:0] br, input logic signed [17:0] bi,
                               input logic cj, input logic [7:0] tg);
    bit done;
    int waited;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; conj_b = cj; in_tag = tg;
    in_valid = 1'b1;
    done = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 50) begin
        checkOutput("accept_timeout", waited, 0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int start, output int lat);
    lat = start;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sbq.size() != 0 || out_valid0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    tests = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; conj_b = 1'b0; in_tag = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid0, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_y_re", y_re0, 0);
    checkOutput("rst_y_im", y_im0, 0);
    checkOutput("rst_tag", out_tag0, 0);
    checkOutput("rst_sat", sat0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: latency and value.
    applyStimulus(16'sd3, 16'sd4, 18'sd5, 18'sd6, 1'b0, 8'h11);
    wait_out_valid(1, lat);
    checkOutput("latency", lat, 3);
    checkOutput("t1_y_re", y_re0, -9);
    checkOutput("t1_y_im", y_im0, 38);
    checkOutput("t1_tag", out_tag0, 8'h11);
    drain();

    // Back-to-back plain then conjugate beat.
    applyStimulus(16'sd3, 16'sd4, 18'sd5, 18'sd6, 1'b0, 8'h11);
    applyStimulus(16'sd3, 16'sd4, 18'sd5, 18'sd6, 1'b1, 8'h12);
    @(posedge clk); #1;
    checkOutput("t2a_y_re", y_re0, -9);
    checkOutput("t2a_y_im", y_im0, 38);
    @(posedge clk); #1;
    checkOutput("t2b_y_re", y_re0, 39);
    checkOutput("t2b_y_im", y_im0, 2);
    checkOutput("t2b_tag", out_tag0, 8'h12);
    drain();

    // Most negative operands in every product.
    applyStimulus(-16'sd32768, -16'sd32768, -18'sd131072, -18'sd131072, 1'b0, 8'h33);
    wait_out_valid(1, lat);
    checkOutput("corner_y_re", y_re0, 0);
    checkOutput("corner_y_im", y_im0, longint'(1) <<< 33);
    checkOutput("corner_sat", sat0, 0);
    drain();

    // Narrow instance: saturation/wrap and rounding.
    applyStimulus(16'sd100, 16'sd0, 18'sd100, 18'sd0, 1'b0, 8'h51);
    applyStimulus(16'sd3, 16'sd0, 18'sd3, 18'sd0, 1'b0, 8'h52);
    @(posedge clk); #1;
`ifdef ROUND_SAT_EN
    checkOutput("narrow_big_y_re", y_re1, 127);
    checkOutput("narrow_big_sat", sat1, 1);
`else
    checkOutput("narrow_big_y_re", y_re1, 8'h71);
    checkOutput("narrow_big_sat", sat1, 0);
`endif
    @(posedge clk); #1;
`ifdef ROUND_SAT_EN
    checkOutput("narrow_small_y_re", y_re1, 1);
`else
    checkOutput("narrow_small_y_re", y_re1, 0);
`endif
    checkOutput("narrow_small_sat", sat1, 0);
    drain();

    // Backpressure: five beats streamed while the sink stalls for five cycles.
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(16'($urandom), 16'($urandom), 18'($urandom), 18'($urandom),
                        1'($urandom), 8'(8'h40 + i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with a full, stalled pipe.
    out_ready = 1'b0;
    applyStimulus(16'sd3, 16'sd4, 18'sd5, 18'sd6, 1'b0, 8'h21);
    applyStimulus(16'sd7, 16'sd1, 18'sd2, 18'sd9, 1'b1, 8'h22);
    applyStimulus(16'sd8, 16'sd2, 18'sd3, 18'sd4, 1'b0, 8'h23);
    checkOutput("full_out_valid", out_valid0, 1);
    checkOutput("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid0, 0);
    checkOutput("midrst_y_re", y_re0, 0);
    checkOutput("midrst_y_im", y_im0, 0);
    checkOutput("midrst_tag", out_tag0, 0);
    checkOutput("midrst_out_valid1", out_valid1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1'b1;
    end
    checkOutput("post_rst_no_stale", seen, 0);
    applyStimulus(16'sd3, 16'sd4, 18'sd5, 18'sd6, 1'b1, 8'h61);
    wait_out_valid(1, lat);
    checkOutput("post_rst_latency", lat, 3);
    checkOutput("post_rst_y_re", y_re0, 39);
    drain();

    // Random traffic with random backpressure and occasional extreme operands.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_re   = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
      a_im   = 16'($urandom);
      b_re   = 18'($urandom);
      b_im   = ($urandom_range(0, 7) == 0) ? 18'sh20000 : 18'($urandom);
      conj_b = 1'($urandom);
      in_tag = 8'($urandom);
      @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
